// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, FSM state type and helpers for the sprite blocks
package sprite_pkg;

    localparam int GLYPH_W_DEF = 20;
    localparam int GLYPH_H_DEF = 20;

    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    // 10^n, used to size the saturation limit of an n-digit display.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// rtl/digit_glyph_rom.sv - combinational 20x20 decimal glyph lookup
// Ports:
//   digit - BCD code; 10..15 render nothing
//   row   - glyph row 0..19; larger rows render nothing
//   col   - glyph column 0..19; larger columns render nothing
//   ink   - 1 when the glyph pixel is lit
module digit_glyph_rom (
    input  logic [3:0] digit,
    input  logic [4:0] row,
    input  logic [4:0] col,
    output logic       ink
);

    // Segment enables {a,b,c,d,e,f,g}: one small table per digit code.
    logic [6:0] seg;

    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end

    // Stroke geometry: 3-pixel strokes; the vertical halves overlap the
    // middle bar so corners join cleanly.
    logic in_range, h_span, top_band, mid_band, bot_band;
    logic left_band, right_band, upper_half, lower_half;

    always_comb begin
        in_range   = (row < 5'd20) && (col < 5'd20);
        h_span     = (col >= 5'd3)  && (col <= 5'd16);
        top_band   = (row >= 5'd1)  && (row <= 5'd3);
        mid_band   = (row >= 5'd8)  && (row <= 5'd10);
        bot_band   = (row >= 5'd16) && (row <= 5'd18);
        left_band  = (col >= 5'd3)  && (col <= 5'd5);
        right_band = (col >= 5'd14) && (col <= 5'd16);
        upper_half = (row >= 5'd1)  && (row <= 5'd10);
        lower_half = (row >= 5'd8)  && (row <= 5'd18);
        ink = in_range && (
              (seg[6] && top_band   && h_span)     ||
              (seg[5] && right_band && upper_half) ||
              (seg[4] && right_band && lower_half) ||
              (seg[3] && bot_band   && h_span)     ||
              (seg[2] && left_band  && lower_half) ||
              (seg[1] && left_band  && upper_half) ||
              (seg[0] && mid_band   && h_span));
    end

endmodule

// File: rtl/score_digit_renderer.sv
// rtl/score_digit_renderer.sv - N-digit decimal sprite with frame-gated double-dabble conversion
// Ports:
//   clk, reset_n          - pixel clock, synchronous active-low reset
//   value, load           - binary value and its one-cycle capture strobe
//   frame_start           - vsync strobe committing a finished conversion
//   pos_x, pos_y          - top-left corner of the digit box
//   pix_x, pix_y          - current scan pixel
//   fg_color, bg_color    - glyph ink and box background colours
//   transparent           - background pixels inside the box are not hits
//   busy                  - conversion running or pending
//   color_data, hit       - pixel colour and sprite hit, 2 cycles after pix_x/pix_y
module score_digit_renderer
    import sprite_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int VAL_W           = 14,
    parameter int GLYPH_W         = GLYPH_W_DEF,
    parameter int GLYPH_H         = GLYPH_H_DEF,
    parameter int SCALE_LOG2      = 0,
    parameter int COLOR_W         = 12,
    parameter bit LEAD_ZERO_BLANK = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [VAL_W-1:0]   value,
    input  logic               load,
    input  logic               frame_start,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic [COLOR_W-1:0] fg_color,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic               transparent,
    output logic               busy,
    output logic [COLOR_W-1:0] color_data,
    output logic               hit
);

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int          BOX_W   = NUM_DIGITS * GLYPH_W * (1 << SCALE_LOG2);
    localparam int          BOX_H   = GLYPH_H * (1 << SCALE_LOG2);
    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    // ------------------------------------------------------------------
    // Conversion engine
    // ------------------------------------------------------------------
    conv_state_t        state, state_nxt;
    logic [VAL_W-1:0]   value_sat, bin_sh, bin_nxt, pend_val;
    logic [BCD_W-1:0]   bcd_work, bcd_adj, bcd_nxt, bcd_result, bcd_disp;
    logic [CNT_W-1:0]   bit_cnt;
    logic               pend_valid, done, conv_last;

    // Clamping on capture keeps every intermediate BCD value inside BCD_W bits.
    always_comb begin
        value_sat = ({{(64-VAL_W){1'b0}}, value} > MAX_VAL) ? VAL_W'(MAX_VAL) : value;
    end

    always_comb begin
        bcd_adj = bcd_work;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_work[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
            end
        end
        {bcd_nxt, bin_nxt} = {bcd_adj, bin_sh} << 1;
        conv_last = (state == CONV) && (bit_cnt == CNT_W'(VAL_W - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A finishing conversion chains straight into the next one when a
    // value is waiting, so busy never drops between them.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (conv_last && !load && !pend_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONV);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bin_sh     <= '0;
            bcd_work   <= '0;
            bit_cnt    <= '0;
            pend_val   <= '0;
            pend_valid <= 1'b0;
            done       <= 1'b0;
            bcd_result <= '0;
            bcd_disp   <= '0;
        end else begin
            // Commit reads the old result, so a same-cycle completion below
            // re-arms done for the next frame rather than being lost.
            if (frame_start && done) begin
                bcd_disp <= bcd_result;
                done     <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sh   <= value_sat;
                        bcd_work <= '0;
                        bit_cnt  <= '0;
                    end
                end
                CONV: begin
                    if (conv_last) begin
                        bcd_result <= bcd_nxt;
                        done       <= 1'b1;
                        if (load) begin
                            bin_sh     <= value_sat;
                            bcd_work   <= '0;
                            bit_cnt    <= '0;
                            pend_valid <= 1'b0;
                        end else if (pend_valid) begin
                            bin_sh     <= pend_val;
                            bcd_work   <= '0;
                            bit_cnt    <= '0;
                            pend_valid <= 1'b0;
                        end
                    end else begin
                        bin_sh   <= bin_nxt;
                        bcd_work <= bcd_nxt;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        if (load) begin
                            pend_val   <= value_sat;
                            pend_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline, stage 1: box test, digit index, glyph coordinates
    // ------------------------------------------------------------------
    logic [9:0] dx, dy, sx, sy, base;
    logic [2:0] idx;
    logic       in_box;

    always_comb begin
        dx     = pix_x - pos_x;
        dy     = pix_y - pos_y;
        // The >= terms stop a pixel left/above the box from wrapping into it.
        in_box = (pix_x >= pos_x) && ({1'b0, dx} < 11'(BOX_W)) &&
                 (pix_y >= pos_y) && ({1'b0, dy} < 11'(BOX_H));
        sx     = dx >> SCALE_LOG2;
        sy     = dy >> SCALE_LOG2;
        idx    = '0;
        base   = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (sx >= 10'(k * GLYPH_W)) begin
                idx  = 3'(k);
                base = 10'(k * GLYPH_W);
            end
        end
    end

    logic               s1_in, s1_transp;
    logic [2:0]         s1_idx;
    logic [4:0]         s1_row, s1_col;
    logic [COLOR_W-1:0] s1_fg, s1_bg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_in     <= 1'b0;
            s1_transp <= 1'b0;
            s1_idx    <= '0;
            s1_row    <= '0;
            s1_col    <= '0;
            s1_fg     <= '0;
            s1_bg     <= '0;
        end else begin
            s1_in     <= in_box;
            s1_transp <= transparent;
            s1_idx    <= idx;
            s1_row    <= 5'(sy);
            s1_col    <= 5'(sx - base);
            s1_fg     <= fg_color;
            s1_bg     <= bg_color;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: digit select, leading-zero blanking, glyph, colour
    // ------------------------------------------------------------------
    logic [3:0] cur_digit;
    logic       cur_blank, zero_run, rom_ink, glyph_on;

    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_run = zero_run && (bcd_disp[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            if (s1_idx == 3'(k)) begin
                cur_digit = bcd_disp[4*(NUM_DIGITS-1-k) +: 4];
                cur_blank = LEAD_ZERO_BLANK && (k != NUM_DIGITS - 1) && zero_run;
            end
        end
    end

    digit_glyph_rom u_glyph_rom (
        .digit (cur_digit),
        .row   (s1_row),
        .col   (s1_col),
        .ink   (rom_ink)
    );

    always_comb begin
        glyph_on = s1_in && rom_ink && !cur_blank;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            color_data <= COLOR_W'(COLOR_BLACK);
            hit        <= 1'b0;
        end else begin
            color_data <= glyph_on ? s1_fg : s1_bg;
            hit        <= glyph_on || (s1_in && !s1_transp);
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// tb/tb_score_digit_renderer.sv - table and scoreboard bench for score_digit_renderer
`timescale 1ns/1ps
module tb_score_digit_renderer;
    import sprite_pkg::*;

    localparam int N  = 4;
    localparam int S  = 1;
    localparam int GW = 20;
    localparam int GH = 20;
    localparam int BW = N * GW * (1 << S);
    localparam int BH = GH * (1 << S);

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] value;
    logic        load, frame_start;
    logic [9:0]  pos_x, pos_y, pix_x, pix_y;
    logic [11:0] fg_color, bg_color;
    logic        transparent;
    logic        busy;
    logic [11:0] color_data;
    logic        hit;

    always #5 clk = ~clk;

    score_digit_renderer #(
        .NUM_DIGITS(N), .VAL_W(14), .GLYPH_W(GW), .GLYPH_H(GH),
        .SCALE_LOG2(S), .COLOR_W(12), .LEAD_ZERO_BLANK(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load),
        .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
        .pix_x(pix_x), .pix_y(pix_y), .fg_color(fg_color), .bg_color(bg_color),
        .transparent(transparent), .busy(busy), .color_data(color_data), .hit(hit)
    );

    int checks   = 0;
    int failures = 0;

    int disp_exp [N];
    int res_exp;
    bit done_exp;

    typedef struct {
        bit          chk;
        int          x;
        int          y;
        logic [11:0] col;
        logic        hit;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int val;
        int shown;
    } vec_t;
    vec_t vec [10];

    string seg_tab [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic bit seg_on(byte s, int r, int c);
        bit h;
        h = (c >= 3 && c <= 16);
        case (s)
            "a":     return h && r >= 1 && r <= 3;
            "b":     return c >= 14 && c <= 16 && r >= 1 && r <= 10;
            "c":     return c >= 14 && c <= 16 && r >= 8 && r <= 18;
            "d":     return h && r >= 16 && r <= 18;
            "e":     return c >= 3 && c <= 5 && r >= 8 && r <= 18;
            "f":     return c >= 3 && c <= 5 && r >= 1 && r <= 10;
            "g":     return h && r >= 8 && r <= 10;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit glyph(int d, int r, int c);
        string s;
        if (d > 9) return 1'b0;
        s = seg_tab[d];
        for (int i = 0; i < s.len(); i++) begin
            if (seg_on(s[i], r, c)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic exp_t model(int x, int y);
        exp_t e;
        int   px, py, sx, sy, di, col;
        bit   blank;
        px = int'(pos_x);
        py = int'(pos_y);
        e.chk = 1'b1;
        e.x   = x;
        e.y   = y;
        if (x >= px && x - px < BW && y >= py && y - py < BH) begin
            sx    = (x - px) / (1 << S);
            sy    = (y - py) / (1 << S);
            di    = sx / GW;
            col   = sx % GW;
            blank = (di != N - 1);
            for (int i = 0; i <= di; i++) begin
                if (disp_exp[i] != 0) blank = 1'b0;
            end
            if (!blank && glyph(disp_exp[di], sy, col)) begin
                e.col = fg_color;
                e.hit = 1'b1;
            end else begin
                e.col = bg_color;
                e.hit = !transparent;
            end
        end else begin
            e.col = bg_color;
            e.hit = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // One clock: compare the output of the pixel driven two negedges ago,
    // then drive a new pixel and queue its expectation.
    task automatic tick(input bit chk, input int x, input int y);
        exp_t e;
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (color_data !== e.col || hit !== e.hit) begin
                    failures++;
                    $display("FAIL pixel(%0d,%0d): got color=%h hit=%b want color=%h hit=%b",
                             e.x, e.y, color_data, hit, e.col, e.hit);
                end
            end
        end
        pix_x = 10'(x);
        pix_y = 10'(y);
        e = model(x, y);
        e.chk = chk;
        sb.push_back(e);
    endtask

    task automatic flush();
        tick(1'b0, 0, 0);
        tick(1'b0, 0, 0);
    endtask

    task automatic set_disp(input int v);
        disp_exp[0] = (v / 1000) % 10;
        disp_exp[1] = (v / 100) % 10;
        disp_exp[2] = (v / 10) % 10;
        disp_exp[3] = v % 10;
    endtask

    task automatic scan_box();
        for (int r = 0; r < GH; r++) begin
            for (int c = 0; c < N * GW; c++) begin
                tick(1'b1, int'(pos_x) + c * (1 << S) + (r % 2),
                           int'(pos_y) + r * (1 << S) + (c % 2));
            end
        end
        flush();
    endtask

    task automatic do_load(input int v);
        load  = 1'b1;
        value = 14'(v);
        tick(1'b0, 0, 0);
        load  = 1'b0;
    endtask

    // Counts busy-high cycles; optionally injects a second load or a
    // frame_start on a given busy cycle.
    task automatic run_conv(input int load2_at, input int v2, input int fs_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == load2_at) begin
                load  = 1'b1;
                value = 14'(v2);
            end
            if (n == fs_at) frame_start = 1'b1;
            tick(1'b0, 0, 0);
            load        = 1'b0;
            frame_start = 1'b0;
            n++;
        end
    endtask

    task automatic commit();
        flush();
        frame_start = 1'b1;
        if (done_exp) begin
            set_disp(res_exp);
            done_exp = 1'b0;
        end
        tick(1'b0, 0, 0);
        frame_start = 1'b0;
        flush();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec[0] = '{1234, 1234};
        vec[1] = '{12000, 9999};
        vec[2] = '{7, 7};
        vec[3] = '{0, 0};
        vec[4] = '{16383, 9999};
        vec[5] = '{10000, 9999};
        vec[6] = '{9999, 9999};
        vec[7] = '{1000, 1000};
        vec[8] = '{305, 305};
        vec[9] = '{58, 58};

        reset_n = 1'b0; load = 1'b0; frame_start = 1'b0; value = '0;
        pos_x = 10'd100; pos_y = 10'd50; pix_x = '0; pix_y = '0;
        fg_color = COLOR_WHITE; bg_color = 12'h00F; transparent = 1'b0;
        set_disp(0);
        res_exp = 0;
        done_exp = 1'b0;

        repeat (3) tick(1'b0, 0, 0);
        check("reset_busy", int'(busy), 0);
        check("reset_hit", int'(hit), 0);
        check("reset_color", int'(color_data), 0);
        reset_n = 1'b1;
        flush();
        scan_box();

        foreach (vec[i]) begin
            do_load(vec[i].val);
            run_conv(-1, 0, -1, n);
            check($sformatf("busy_len_%0d", vec[i].val), n, 14);
            res_exp  = vec[i].shown;
            done_exp = 1'b1;
            commit();
            scan_box();
        end

        // Load while busy: newest value wins, one long busy period.
        do_load(42);
        run_conv(2, 58, -1, n);
        check("busy_len_pending", n, 28);
        res_exp  = 58;
        done_exp = 1'b1;
        commit();
        scan_box();

        // frame_start in the cycle done is being set must not commit.
        do_load(305);
        run_conv(-1, 0, 13, n);
        check("busy_len_gated", n, 14);
        res_exp  = 305;
        done_exp = 1'b1;
        scan_box();
        commit();
        scan_box();

        // Same-cycle load and frame_start: old result commits, new one converts.
        do_load(1000);
        run_conv(-1, 0, -1, n);
        check("busy_len_1000", n, 14);
        flush();
        load = 1'b1; value = 14'd4321; frame_start = 1'b1;
        set_disp(1000);
        tick(1'b0, 0, 0);
        load = 1'b0; frame_start = 1'b0;
        run_conv(-1, 0, -1, n);
        check("busy_len_same_cycle", n, 14);
        res_exp  = 4321;
        done_exp = 1'b1;
        scan_box();
        commit();
        scan_box();

        // Latency: in-box background pixel appears exactly two cycles later.
        flush();
        tick(1'b0, 100, 60);
        tick(1'b0, 0, 0);
        check("latency_t1_hit", int'(hit), 0);
        tick(1'b0, 0, 0);
        check("latency_t2_hit", int'(hit), 1);
        tick(1'b0, 0, 0);
        check("latency_t3_hit", int'(hit), 0);

        // Box edges on both axes.
        flush();
        tick(1'b1, 99, 60);
        tick(1'b1, 100, 60);
        tick(1'b1, 100 + BW - 1, 60);
        tick(1'b1, 100 + BW, 60);
        tick(1'b1, 150, 49);
        tick(1'b1, 150, 50);
        tick(1'b1, 150, 50 + BH - 1);
        tick(1'b1, 150, 50 + BH);
        flush();

        // Pixel left of a box near the right edge must not wrap into it.
        pos_x = 10'd1000;
        tick(1'b1, 5, 60);
        tick(1'b1, 1010, 60);
        tick(1'b1, 1023, 60);
        flush();
        pos_x = 10'd100;
        flush();

        // Transparency: only ink pixels hit.
        transparent = 1'b1;
        fg_color    = 12'h0F0;
        flush();
        scan_box();
        transparent = 1'b0;
        fg_color    = COLOR_WHITE;
        flush();

        // Reset during conversion with a pending value.
        do_load(9876);
        repeat (3) tick(1'b0, 0, 0);
        load = 1'b1; value = 14'd1111;
        tick(1'b0, 0, 0);
        load = 1'b0;
        tick(1'b0, 0, 0);
        check("mid_busy_before_reset", int'(busy), 1);
        reset_n = 1'b0;
        tick(1'b0, 0, 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_hit", int'(hit), 0);
        check("mid_reset_color", int'(color_data), 0);
        tick(1'b0, 0, 0);
        reset_n = 1'b1;
        set_disp(0);
        done_exp = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 0, 0);
            if (busy !== 1'b0) n++;
        end
        check("post_reset_busy_cycles", n, 0);
        commit();
        scan_box();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_digit_renderer.md
# score_digit_renderer

Parametrised multi-digit decimal sprite renderer for the VGA pixel pipeline. It accepts a binary value, converts it to BCD with a sequential double-dabble engine, and commits the new digits only at frame boundaries. For each scanned pixel it returns a 12-bit colour and a hit flag for an N-digit glyph box at a programmable screen position, with an integer power-of-two scale. It sits beside the other sprite blocks and feeds the top-level colour mux.

## Interface
- NUM_DIGITS, 4: digits displayed (1–6)
- VAL_W, 14: binary input width
- GLYPH_W, 20: glyph width in source pixels
- GLYPH_H, 20: glyph height in source pixels
- SCALE_LOG2, 0: each glyph pixel drawn as a 2^SCALE_LOG2 square (0–2)
- COLOR_W, 12: colour width (4:4:4)
- LEAD_ZERO_BLANK, 1: blank leading zeros; the rightmost digit is always drawn

Ports:
- clk  in  1  pixel clock, single clock domain
- reset_n  in  1  synchronous, active-low reset
- value  in  VAL_W  binary value to display
- load  in  1  one-cycle strobe that captures `value`
- frame_start  in  1  one-cycle strobe at vsync that commits completed digits
- pos_x, pos_y  in  10  top-left corner of the box in screen coordinates
- pix_x, pix_y  in  10  current scan pixel
- fg_color, bg_color  in  COLOR_W  glyph ink and box background
- transparent  in  1  when 1, background pixels inside the box are not hits
- busy  out  1  conversion in progress or pending
- color_data  out  COLOR_W  pixel colour
- hit  out  1  pixel belongs to the drawn sprite

## Operation
- **Reset** (reset_n=0 at a clock edge):
  - FSM goes to IDLE; busy=0, hit=0, color_data=0.
  - Display BCD, working BCD, pending flag and done flag are all cleared, so the block displays "0".
- **Saturation:** on capture, a value above 10^NUM_DIGITS−1 is clamped to all nines.
- **FSM states:**
  - IDLE: a `load` captures the saturated value into the shift register, clears the BCD register, and moves to CONV.
  - CONV: each cycle, every BCD nibble that is ≥5 gets +3, then {bcd, bin} shifts left by one. After exactly VAL_W cycles, the result goes to the result register, done is set, and the FSM moves to IDLE.
- **Load while busy:** a `load` in CONV stores the value in a one-deep pending register; the newest value wins. When CONV finishes with pending set, the FSM re-enters CONV on the next cycle with the pending value.
- **Commit:** `frame_start` with done=1 copies the result register to the display register and clears done. With done=0, nothing changes. Digits never change mid-frame.
- **Pixel path:**
  - Box size: W = NUM_DIGITS·GLYPH_W·2^S, H = GLYPH_H·2^S.
  - Inside the box when pix ≥ pos and (pix−pos) < W/H on each axis, using unsigned compare with no wrap.
  - sx = (pix_x−pos_x)>>S and sy = (pix_y−pos_y)>>S.
  - Digit index = sx/GLYPH_W, computed with a constant-multiple comparator chain (no divider); col = sx − idx·GLYPH_W, row = sy. Index 0 is the leftmost, most significant digit.
- **Blanking:** a digit is blank if LEAD_ZERO_BLANK=1, it is not the last digit, and it and all digits to its left are 0.
- **Output colour:**
  - Glyph bit 1 on a non-blank digit: fg_color, hit=1.
  - Other in-box pixels: bg_color, with hit=!transparent.
  - Outside the box: bg_color, hit=0.

## Timing
- Pixel latency is 2 cycles: pix_x/pix_y at cycle t produce color_data/hit at t+2.
  - Stage 1 registers in-box, idx, row and col.
  - Stage 2 registers the glyph lookup and colour select.
- pos, colour and transparent inputs are sampled in stage 1.
- busy rises the cycle after `load` and stays high through CONV, including pending restarts. It falls in the cycle done is set. Conversion takes VAL_W cycles.
- **Commit ordering:**
  - done is registered, so a conversion finishing at cycle t is committed only by a frame_start at t+1 or later.
  - `load` and `frame_start` in the same cycle are independent: commit of the old result plus start of the new conversion.
- A reset mid-conversion aborts it and drops the pending value.

## Structure
- Package `sprite_pkg`:
  - GLYPH_W/GLYPH_H defaults
  - COLOR_BLACK/COLOR_WHITE constants
  - FSM state enum {IDLE, CONV}
- Sub-module `digit_glyph_rom`: combinational (digit[3:0], row[4:0], col[4:0]) → 1-bit ink, with distributed-ROM style. Digit codes 10–15 and out-of-range row/col return 0.

## Test plan
- **Reset and basic conversion:** after reset, scan the box at pos (100,50) → only the rightmost "0" glyph is ink. Then load 1234 and wait 14 cycles → busy high for exactly 14 cycles. Pulse frame_start → digits 1,2,3,4 render in fg_color.
- **Saturation and blanking:** load 12000 (NUM_DIGITS=4) → displays 9999. Load 7 → displays "7" with three blank leading positions, bg in box.
- **Load while busy:** load 42, then load 58 three cycles later → busy stays high ~28 cycles. After commit the display shows 58, never 42.
- **Frame-gated commit:** finish a conversion and scan without frame_start → old digits persist. Pulse frame_start the cycle after done → new digits next frame.
- **Latency, boundaries and transparency:** with S=1, pixel (pos_x−1) gives hit=0 and pixel pos_x gives a hit 2 cycles later. Pixel pos_x+W−1 is in the box and pos_x+W is out. transparent=1 gives hit only on ink pixels.
- **Reset mid-conversion:** assert reset_n=0 during CONV → busy=0, display "0", and the pending load is discarded.
